// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: controller
// state encoding and the default operand width.
package div_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      SHIFT = 3'd2,
      TEST  = 3'd3,
      DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for the sequential divider.
// The master side issues start with operands; the slave side computes.
interface seq_divider_if
   import div_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             busy;
   logic             done;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  quotient, remainder, busy, done, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output quotient, remainder, busy, done, div_by_zero
   );
endinterface

// File: rtl/div_datapath.sv
// Datapath of the restoring divider: partial remainder R, dividend/quotient
// shift register Q, divisor D, bit counter and the trial subtractor.
// The post-TEST values of Q and R are exposed so the controller can latch
// the final result in the same cycle as the last TEST update.
module div_datapath
   import div_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic             test,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             borrow,
   output logic             cnt_last,
   output logic [WIDTH-1:0] q_final,
   output logic [WIDTH-1:0] r_final
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [WIDTH:0]   r_reg;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] d_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [WIDTH+1:0] diff;

   // One extra bit beyond R makes the borrow of R - D explicit.
   assign diff     = {1'b0, r_reg} - {2'b00, d_reg};
   assign borrow   = diff[WIDTH+1];
   assign cnt_last = (cnt_reg == CNT_W'(WIDTH - 1));
   assign q_final  = {q_reg[WIDTH-1:1], ~borrow};
   assign r_final  = borrow ? r_reg[WIDTH-1:0] : diff[WIDTH-1:0];

   // Register updates driven by the controller's load/shift/test strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_reg   <= '0;
         q_reg   <= '0;
         d_reg   <= '0;
         cnt_reg <= '0;
      end else if (load) begin
         r_reg   <= '0;
         q_reg   <= dividend;
         d_reg   <= divisor;
         cnt_reg <= '0;
      end else if (shift) begin
         {r_reg, q_reg} <= {r_reg[WIDTH-1:0], q_reg, 1'b0};
      end else if (test) begin
         if (!borrow) begin
            r_reg <= diff[WIDTH:0];
         end
         q_reg[0] <= ~borrow;
         cnt_reg  <= cnt_reg + 1'b1;
      end
   end
endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: controller FSM plus result registers,
// one quotient bit per SHIFT/TEST pair. A zero divisor short-circuits
// from LOAD straight to DONE with a saturated quotient.
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic          clk,
   input  logic          rst,
   seq_divider_if.slave  bus
);
   state_t           state_reg;
   state_t           state_next;
   logic             load_st;
   logic             shift_st;
   logic             test_st;
   logic             divisor_zero;
   logic             borrow;
   logic             cnt_last;
   logic [WIDTH-1:0] q_final;
   logic [WIDTH-1:0] r_final;
   logic [WIDTH-1:0] quotient_reg;
   logic [WIDTH-1:0] remainder_reg;
   logic             dbz_reg;

   assign load_st      = (state_reg == LOAD);
   assign shift_st     = (state_reg == SHIFT);
   assign test_st      = (state_reg == TEST);
   assign divisor_zero = (bus.divisor == '0);

   div_datapath #(.WIDTH(WIDTH)) u_datapath (
      .clk      (clk),
      .rst      (rst),
      .load     (load_st),
      .shift    (shift_st),
      .test     (test_st),
      .dividend (bus.dividend),
      .divisor  (bus.divisor),
      .borrow   (borrow),
      .cnt_last (cnt_last),
      .q_final  (q_final),
      .r_final  (r_final)
   );

   // Controller state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state decode; start is only honoured in IDLE.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (bus.start) state_next = LOAD;
         LOAD:    state_next = divisor_zero ? DONE : SHIFT;
         SHIFT:   state_next = TEST;
         TEST:    state_next = cnt_last ? DONE : SHIFT;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Result registers change only on entry to DONE and hold otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         quotient_reg  <= '0;
         remainder_reg <= '0;
         dbz_reg       <= 1'b0;
      end else if (load_st && divisor_zero) begin
         quotient_reg  <= '1;
         remainder_reg <= bus.dividend;
         dbz_reg       <= 1'b1;
      end else if (test_st && cnt_last) begin
         quotient_reg  <= q_final;
         remainder_reg <= r_final;
         dbz_reg       <= 1'b0;
      end
   end

   assign bus.quotient    = quotient_reg;
   assign bus.remainder   = remainder_reg;
   assign bus.div_by_zero = dbz_reg;
   assign bus.busy        = load_st || shift_st || test_st;
   assign bus.done        = (state_reg == DONE);
endmodule
